// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int unsigned DIV_MIN = 2;
    localparam int unsigned DIV_W   = 8;

    typedef logic [DIV_W-1:0] div_t;

    // Ratios below DIV_MIN cannot produce a high and a low phase, so they are raised.
    function automatic int unsigned clamp_div(input int unsigned value);
        return (value < DIV_MIN) ? DIV_MIN : value;
    endfunction

endpackage

// File: rtl/prog_div_core.sv
// Programmable divide-by-R counter with a glitch-free ratio-load handshake.
module prog_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_busy,
    output logic             div_ack,
    output logic             div_clk,
    output logic             div_tick
);

    localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(clamp_div(DEFAULT_DIV));

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ratio_q;
    logic [CNT_W-1:0] pend;
    logic [CNT_W-1:0] cnt_next;
    logic             wrap;
    logic             apply;

    // A pending ratio is only swapped in at the period boundary, or at once while
    // counting is paused; a clear postpones it to the next real wrap.
    always_comb begin
        wrap     = (cnt == ratio_q - CNT_W'(1));
        cnt_next = wrap ? '0 : cnt + CNT_W'(1);
        apply    = div_busy && !clr && (!en || wrap);
    end

    // NOTE: every register here uses <= so all of them see the pre-edge values of
    // cnt, ratio_q and pend; mixing in blocking writes would make order matter.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            ratio_q  <= RESET_DIV;
            pend     <= RESET_DIV;
            div_busy <= 1'b0;
            div_ack  <= 1'b0;
            div_clk  <= 1'b0;
            div_tick <= 1'b0;
        end else begin
            div_ack  <= apply;
            div_busy <= div_load || (div_busy && !apply);
            if (div_load)
                pend <= CNT_W'(clamp_div(32'(div_val)));

            if (clr) begin
                cnt      <= '0;
                div_clk  <= 1'b0;
                div_tick <= 1'b0;
            end else begin
                div_tick <= en && (cnt_next == '0);
                if (en)
                    div_clk <= (cnt_next < (ratio_q >> 1));
                if (apply) begin
                    ratio_q <= pend;
                    cnt     <= '0;
                end else if (en) begin
                    cnt <= cnt_next;
                end
            end
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// Synchronous binary tap divider plus programmable divide-by-R output.
// Optional synchronous clear input enabled by PROG_CLK_DIVIDER_SYNC_CLR_EN.
module prog_clk_divider
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int NUM_TAPS    = 4,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                en,
`ifdef PROG_CLK_DIVIDER_SYNC_CLR_EN
    input  logic                clr,
`endif
    input  logic [CNT_W-1:0]    div_val,
    input  logic                div_load,
    output logic                div_busy,
    output logic                div_ack,
    output logic [NUM_TAPS-1:0] taps,
    output logic                div_clk,
    output logic                div_tick
);

    logic clr_int;

`ifdef PROG_CLK_DIVIDER_SYNC_CLR_EN
    assign clr_int = clr;
`else
    assign clr_int = 1'b0;
`endif

    // All taps come from one counter, so they switch on the same edge.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)
            taps <= '0;
        else if (clr_int)
            taps <= '0;
        else if (en)
            taps <= taps + NUM_TAPS'(1);
    end

    prog_div_core #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_core (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .clr      (clr_int),
        .div_val  (div_val),
        .div_load (div_load),
        .div_busy (div_busy),
        .div_ack  (div_ack),
        .div_clk  (div_clk),
        .div_tick (div_tick)
    );

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider: directed steps then randomized traffic.
module tb_prog_clk_divider;

    localparam int CNT_W       = 8;
    localparam int NUM_TAPS    = 4;
    localparam int DEFAULT_DIV = 4;

    logic                clk_in   = 1'b0;
    logic                rst      = 1'b1;
    logic                en       = 1'b0;
    logic                clr      = 1'b0;
    logic [CNT_W-1:0]    div_val  = '0;
    logic                div_load = 1'b0;
    logic                div_busy;
    logic                div_ack;
    logic [NUM_TAPS-1:0] taps;
    logic                div_clk;
    logic                div_tick;

    prog_clk_divider #(
        .CNT_W       (CNT_W),
        .NUM_TAPS    (NUM_TAPS),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
`ifdef PROG_CLK_DIVIDER_SYNC_CLR_EN
        .clr      (clr),
`endif
        .div_val  (div_val),
        .div_load (div_load),
        .div_busy (div_busy),
        .div_ack  (div_ack),
        .taps     (taps),
        .div_clk  (div_clk),
        .div_tick (div_tick)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    // Reference model: position within the current period, active ratio, pending request.
    int m_ratio, m_phase, m_pend, m_taps;
    bit m_pv, m_clk, m_tick, m_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp_model(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_reset();
        m_ratio = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
        m_phase = 0;
        m_pend  = 0;
        m_taps  = 0;
        m_pv    = 1'b0;
        m_clk   = 1'b0;
        m_tick  = 1'b0;
        m_ack   = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit ld, input int v, input bit c);
        bit apply;
        apply = m_pv && !c && (!e || (m_phase == m_ratio - 1));
        m_ack = apply;
        if (c) begin
            m_phase = 0;
            m_taps  = 0;
            m_clk   = 1'b0;
            m_tick  = 1'b0;
        end else begin
            if (e)
                m_taps = (m_taps + 1) % (1 << NUM_TAPS);
            if (apply) begin
                m_ratio = m_pend;
                m_phase = 0;
            end else if (e) begin
                m_phase = (m_phase + 1) % m_ratio;
            end
            if (e)
                m_clk = (m_phase < m_ratio / 2);
            m_tick = e && (m_phase == 0);
        end
        m_pv = (m_pv && !apply) || ld;
        if (ld)
            m_pend = clamp_model(v);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".taps"},     32'(taps),            32'(m_taps));
        check({tag, ".div_clk"},  32'(div_clk),         32'(m_clk));
        check({tag, ".div_tick"}, 32'(div_tick),        32'(m_tick));
        check({tag, ".div_busy"}, 32'(div_busy),        32'(m_pv));
        check({tag, ".div_ack"},  32'(div_ack),         32'(m_ack));
        check({tag, ".cnt"},      32'(dut.u_core.cnt),  32'(m_phase));
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic cycle(input string tag, input bit e, input bit ld, input int v, input bit c);
        en       = e;
        div_load = ld;
        div_val  = CNT_W'(v);
        clr      = c;
        @(posedge clk_in);
        model_step(e, ld, v, c);
        #1;
        check_all(tag);
    endtask

    task automatic wait_phase(input string tag, input int p);
        int n = 0;
        while (m_phase != p && n < 40) begin
            cycle(tag, 1'b1, 1'b0, 0, 1'b0);
            n++;
        end
        check({tag, ".reached"}, 32'(m_phase), 32'(p));
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        while (div_ack !== 1'b1 && n < 40) begin
            cycle(tag, 1'b1, 1'b0, 0, 1'b0);
            n++;
        end
        check({tag, ".ack_seen"}, 32'(div_ack), 32'd1);
    endtask

    // Entered on a period's first cycle; checks the high count and tick count over R cycles.
    task automatic measure(input string tag, input int r);
        int highs, ticks;
        highs = int'(div_clk);
        ticks = int'(div_tick);
        for (int i = 1; i < r; i++) begin
            cycle(tag, 1'b1, 1'b0, 0, 1'b0);
            highs += int'(div_clk);
            ticks += int'(div_tick);
        end
        check({tag, ".highs"}, 32'(highs), 32'(r / 2));
        check({tag, ".ticks"}, 32'(ticks), 32'd1);
    endtask

    initial begin
        logic [NUM_TAPS-1:0] h_taps;
        logic                h_clk;
        int                  acks;

        // Reset
        model_reset();
        @(posedge clk_in);
        #1;
        check_all("reset");
        check("reset.ratio", 32'(dut.u_core.ratio_q), 32'd4);
        rst = 1'b0;

        // Default ratio 4 from reset
        for (int i = 0; i < 16; i++) begin
            cycle("dflt", 1'b1, 1'b0, 0, 1'b0);
            check("dflt.clk_pat", 32'(div_clk),  32'(((i + 1) % 4) < 2));
            check("dflt.tick",    32'(div_tick), 32'(((i + 1) % 4) == 0));
            check("dflt.taps",    32'(taps),     32'((i + 1) % 16));
        end

        // Load 6 while cnt = 1
        wait_phase("ld6.align", 1);
        cycle("ld6.req", 1'b1, 1'b1, 6, 1'b0);
        check("ld6.busy", 32'(div_busy), 32'd1);
        wait_ack("ld6.wait");
        check("ld6.ratio", 32'(dut.u_core.ratio_q), 32'd6);
        measure("ld6.period", 6);

        // Clamp: load 1 gives ratio 2
        cycle("ld1.req", 1'b1, 1'b1, 1, 1'b0);
        wait_ack("ld1.wait");
        check("ld1.ratio", 32'(dut.u_core.ratio_q), 32'd2);
        measure("ld1.period", 2);

        // Odd ratio 5
        cycle("ld5.req", 1'b1, 1'b1, 5, 1'b0);
        wait_ack("ld5.wait");
        measure("ld5.period", 5);
        measure("ld5.period2", 5);

        // Enable low: everything holds, no tick
        wait_phase("hold.align", 2);
        h_taps = taps;
        h_clk  = div_clk;
        for (int i = 0; i < 3; i++) begin
            cycle("hold", 1'b0, 1'b0, 0, 1'b0);
            check("hold.taps", 32'(taps),     32'(h_taps));
            check("hold.clk",  32'(div_clk),  32'(h_clk));
            check("hold.tick", 32'(div_tick), 32'd0);
        end

        // Two loads before the wrap: last one wins, single ack
        wait_phase("ovr.align", 0);
        cycle("ovr.req7", 1'b1, 1'b1, 7, 1'b0);
        cycle("ovr.idle", 1'b1, 1'b0, 0, 1'b0);
        cycle("ovr.req3", 1'b1, 1'b1, 3, 1'b0);
        acks = 0;
        for (int i = 0; i < 14; i++) begin
            cycle("ovr.run", 1'b1, 1'b0, 0, 1'b0);
            acks += int'(div_ack);
        end
        check("ovr.acks",  32'(acks), 32'd1);
        check("ovr.ratio", 32'(dut.u_core.ratio_q), 32'd3);

        // Reset mid-run discards a pending load
        cycle("rst.req", 1'b1, 1'b1, 9, 1'b0);
        rst = 1'b1;
        model_reset();
        #2;
        check_all("rst.async");
        check("rst.ratio", 32'(dut.u_core.ratio_q), 32'd4);
        rst = 1'b0;
        for (int i = 0; i < 12; i++)
            cycle("rst.after", 1'b1, 1'b0, 0, 1'b0);

`ifdef PROG_CLK_DIVIDER_SYNC_CLR_EN
        // Clear at cnt = 2 with a load pending
        wait_phase("clr.align", 0);
        cycle("clr.req", 1'b1, 1'b1, 6, 1'b0);
        cycle("clr.step", 1'b1, 1'b0, 0, 1'b0);
        check("clr.at2", 32'(dut.u_core.cnt), 32'd2);
        cycle("clr.pulse", 1'b1, 1'b0, 0, 1'b1);
        check("clr.taps", 32'(taps), 32'd0);
        check("clr.cnt",  32'(dut.u_core.cnt), 32'd0);
        check("clr.busy", 32'(div_busy), 32'd1);
        wait_ack("clr.wait");
        check("clr.ratio", 32'(dut.u_core.ratio_q), 32'd6);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            bit e, ld, c;
            int v;
            e  = ($urandom_range(0, 7) != 0);
            ld = ($urandom_range(0, 7) == 0);
            v  = int'($urandom_range(0, 9));
            c  = 1'b0;
`ifdef PROG_CLK_DIVIDER_SYNC_CLR_EN
            c  = ($urandom_range(0, 31) == 0);
`endif
            cycle("rand", e, ld, v, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
